lsu_data_ram: RTL

Parametrised, byte-addressable data RAM for the RISC-V core's load/store path. It accepts one valid/ready request per cycle and supports byte, half and word access, with sign or zero extension on loads. Every accepted request gets a registered response one cycle later, including an error flag for misaligned or out-of-range accesses. An optional post-reset clear sequencer zeroes the array one word per cycle.

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_data_ram_if.sv | 31 +++
 rtl/lsu_lane_align.sv | 54 +++++
 rtl/lsu_data_ram.sv | 121 ++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store-unit types: access size codes, data-RAM FSM states, word width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Ports: none.
package lsu_pkg;

   localparam int XLEN = 32;

   // Access size codes as carried on req_size; 2'b11 is illegal.
   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   typedef enum logic {
      DMEM_CLEAR = 1'b0,
      DMEM_RUN   = 1'b1
   } dmem_state_t;

endpackage

// File: rtl/lsu_data_ram_if.sv
// Request/response bundle between a load/store master and the data RAM.
// Latency: n/a (wires only); the response follows an accepted request by one cycle.
// Backpressure: req_valid/req_ready on the request side only; responses cannot be stalled.
// Ports: req_valid, req_ready, req_we, req_size, req_unsigned, req_addr, req_wdata,
//        rsp_valid, rsp_rdata, rsp_err. Modports: master (requester), slave (RAM).
interface lsu_data_ram_if
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic              rsp_valid;
   logic [XLEN-1:0]   rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the data RAM: store lane enables/shifted data, load extract/extend, misalignment.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; evaluated every cycle from the current request.
// Ports: size, lane (addr[1:0]), is_unsigned, wdata, rword (stored word) in;
//        be, wdata_lane, rdata, misalign out (misalign also covers the illegal size code).
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]      size,
   input  logic [1:0]      lane,
   input  logic            is_unsigned,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rword,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata_lane,
   output logic [XLEN-1:0] rdata,
   output logic            misalign
);
   logic [XLEN-1:0] rshift;
   logic            sx;

   // Bring the addressed lane down to bit 0 so byte/half extraction is a fixed slice.
   assign rshift = rword >> {lane, 3'b000};
   assign sx     = ~is_unsigned;

   always_comb begin
      be         = 4'b0000;
      wdata_lane = '0;
      rdata      = '0;
      misalign   = 1'b0;
      unique case (size)
         SIZE_B: begin
            be         = 4'b0001 << lane;
            wdata_lane = {4{wdata[7:0]}};
            rdata      = {{24{sx & rshift[7]}}, rshift[7:0]};
         end
         SIZE_H: begin
            misalign   = lane[0];
            be         = lane[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{wdata[15:0]}};
            rdata      = {{16{sx & rshift[15]}}, rshift[15:0]};
         end
         SIZE_W: begin
            misalign   = (lane != 2'b00);
            be         = 4'b1111;
            wdata_lane = wdata;
            rdata      = rword;
         end
         default: begin
            misalign   = 1'b1;
         end
      endcase
   end
endmodule

// File: rtl/lsu_data_ram.sv
// Byte-addressable data RAM for the load/store path, with optional post-reset zero fill.
// Latency: 1 cycle from accepted request to registered response; 1 request per cycle.
// Backpressure: req_ready low during reset and (if built in) the clear sweep; no response stall.
// Ports: clk, rst_n (synchronous, active-low); bus (lsu_data_ram_if.slave) carrying the
//        valid/ready request and the rsp_valid/rsp_rdata/rsp_err response.
// Build option: define LSU_DATA_RAM_CLEAR_EN to zero the array one word per cycle after reset.
module lsu_data_ram
   import lsu_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 16
)(
   input  logic           clk,
   input  logic           rst_n,
   lsu_data_ram_if.slave  bus
);
   localparam int IDX_W = ADDR_W - 2;
   localparam int PTR_W = $clog2(DEPTH);

   logic [XLEN-1:0]  mem [DEPTH];

   logic [IDX_W-1:0] idx;
   logic [PTR_W-1:0] row;
   logic             oob;
   logic             err;
   logic             accept;
   logic             st_we;
   logic             running;
   logic [3:0]       be;
   logic [XLEN-1:0]  wdata_lane;
   logic [XLEN-1:0]  rdata_ext;
   logic             misalign;

   logic             wr_en;
   logic [PTR_W-1:0] wr_row;
   logic [3:0]       wr_be;
   logic [XLEN-1:0]  wr_dat;

   assign idx = bus.req_addr[ADDR_W-1:2];
   assign row = idx[PTR_W-1:0];
   // Extra zero bit so the compare also works when DEPTH == 2^IDX_W.
   assign oob = ({1'b0, idx} >= (IDX_W+1)'(DEPTH));
   assign err = misalign | oob;

   lsu_lane_align u_align (
      .size        (bus.req_size),
      .lane        (bus.req_addr[1:0]),
      .is_unsigned (bus.req_unsigned),
      .wdata       (bus.req_wdata),
      .rword       (mem[row]),
      .be          (be),
      .wdata_lane  (wdata_lane),
      .rdata       (rdata_ext),
      .misalign    (misalign)
   );

`ifdef LSU_DATA_RAM_CLEAR_EN
   dmem_state_t      state;
   logic [PTR_W-1:0] clr_ptr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= DMEM_CLEAR;
         clr_ptr <= '0;
      end else if (state == DMEM_CLEAR) begin
         clr_ptr <= clr_ptr + 1'b1;
         if (clr_ptr == PTR_W'(DEPTH - 1)) begin
            state <= DMEM_RUN;
         end
      end
   end

   assign running = (state == DMEM_RUN);
`else
   assign running = 1'b1;
`endif

   // Gated by rst_n so nothing is accepted, and nothing written, on a reset edge.
   assign bus.req_ready = rst_n & running;
   assign accept        = bus.req_valid & bus.req_ready;
   assign st_we         = accept & bus.req_we & ~err;

   // Single write port shared by the clear sweep and stores.
   always_comb begin
      wr_en  = st_we;
      wr_row = row;
      wr_be  = be;
      wr_dat = wdata_lane;
`ifdef LSU_DATA_RAM_CLEAR_EN
      if (!running) begin
         wr_en  = 1'b1;
         wr_row = clr_ptr;
         wr_be  = 4'b1111;
         wr_dat = '0;
      end
`endif
   end

   // Array has no reset; the rst_n term only blocks writes on reset edges.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
               mem[wr_row][8*i +: 8] <= wr_dat[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_rdata <= '0;
      end else begin
         bus.rsp_valid <= accept;
         bus.rsp_err   <= accept & err;
         bus.rsp_rdata <= (accept && !err && !bus.req_we) ? rdata_ext : '0;
      end
   end
endmodule
